// File: rtl/square_f32_iterative.sv
`timescale 1ns/1ps
// Sequential IEEE-754 f32 squarer: 24x24 shift-add mantissa product, one bit per cycle,
// round-to-nearest-even, saturation to +inf and flush to +0. Operand sign is discarded.
//
// state | meaning
// IDLE  | waiting for the first start after reset
// MULT  | accumulating m<<counter for each set bit of m, LSB first
// NORM  | normalise, round, range-check and register the result
// DONE  | result and flags held with rdy=1; start restarts immediately
module square_f32_iterative #(
    parameter int WIDTH         = 32,
    parameter int EXPONENTWIDTH = 8,
    parameter int MANTISSAWIDTH = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             rdy,
    output logic [WIDTH-1:0] sq,
    output logic             overflow,
    output logic             underflow
);
    localparam int EW = EXPONENTWIDTH;
    localparam int FW = MANTISSAWIDTH;
    localparam int MW = FW + 1;
    localparam int PW = 2 * MW;
    localparam int XW = EW + 2;
    localparam int CW = $clog2(MW);

    localparam logic [EW-1:0]        EXP_MAX  = '1;
    localparam logic signed [XW-1:0] BIAS     = XW'((1 << (EW - 1)) - 1);
    localparam logic signed [XW-1:0] E_MAX    = XW'((1 << EW) - 1);
    localparam logic signed [XW-1:0] ONE      = XW'(1);
    localparam logic signed [XW-1:0] ZERO     = '0;
    localparam logic [CW-1:0]        CNT_LAST = CW'(MW - 1);
    localparam logic [WIDTH-1:0]     POS_INF  = {1'b0, {EW{1'b1}}, {FW{1'b0}}};
    localparam logic [WIDTH-1:0]     QNAN     = {1'b0, {EW{1'b1}}, 1'b1, {(FW - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] prod;
    logic [MW-1:0] m;
    logic [EW-1:0] exp_r;

    logic [EW-1:0] a_exp;
    logic [FW-1:0] a_frac;
    logic          unused_sign;

    assign a_exp       = a[WIDTH-2 -: EW];
    assign a_frac      = a[FW-1:0];
    assign unused_sign = a[WIDTH-1];

    logic signed [XW-1:0] e2_norm;
    logic signed [XW-1:0] e2_fin;
    logic [FW-1:0]        frac_t;
    logic [FW:0]          frac_sum;
    logic                 guard;
    logic                 sticky;
    logic                 round_up;
    logic                 carry;

    // Product of two 1.x mantissas lies in [1,4); bit PW-1 selects the binade.
    always_comb begin
        e2_norm = $signed({1'b0, exp_r, 1'b0}) - BIAS;
        if (prod[PW-1]) begin
            frac_t  = prod[PW-2 -: FW];
            guard   = prod[PW-2-FW];
            sticky  = |prod[PW-3-FW:0];
            e2_norm = e2_norm + ONE;
        end else begin
            frac_t  = prod[PW-3 -: FW];
            guard   = prod[PW-3-FW];
            sticky  = |prod[PW-4-FW:0];
        end
        round_up = guard & (sticky | frac_t[0]);
        frac_sum = {1'b0, frac_t} + {{FW{1'b0}}, round_up};
        carry    = frac_sum[FW];
        e2_fin   = carry ? e2_norm + ONE : e2_norm;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            rdy       <= 1'b0;
            sq        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            cnt       <= '0;
            prod      <= '0;
            m         <= '0;
            exp_r     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        rdy       <= 1'b0;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        exp_r     <= a_exp;
                        m         <= {1'b1, a_frac};
                        prod      <= '0;
                        cnt       <= '0;
                        if (a_exp == '0) begin
                            sq    <= '0;
                            busy  <= 1'b0;
                            rdy   <= 1'b1;
                            state <= DONE;
                        end else if (a_exp == EXP_MAX) begin
                            sq    <= (a_frac == '0) ? POS_INF : QNAN;
                            busy  <= 1'b0;
                            rdy   <= 1'b1;
                            state <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= MULT;
                        end
                    end
                end
                MULT: begin
                    if (m[cnt]) begin
                        prod <= prod + (PW'(m) << cnt);
                    end
                    if (cnt == CNT_LAST) begin
                        state <= NORM;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                NORM: begin
                    if (e2_fin >= E_MAX) begin
                        sq       <= POS_INF;
                        overflow <= 1'b1;
                    end else if (e2_fin <= ZERO) begin
                        sq        <= '0;
                        underflow <= 1'b1;
                    end else begin
                        sq <= {1'b0, e2_fin[EW-1:0], frac_sum[FW-1:0]};
                    end
                    busy  <= 1'b0;
                    rdy   <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_square_f32_iterative.sv
`timescale 1ns/1ps
// Directed and randomised bench for square_f32_iterative with a queued scoreboard of
// expected results, latencies and flags.
module tb_square_f32_iterative;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic        busy;
    logic        rdy;
    logic [31:0] sq;
    logic        overflow;
    logic        underflow;

    square_f32_iterative dut (
        .clk(clk), .rst(rst), .start(start), .a(a),
        .busy(busy), .rdy(rdy), .sq(sq), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sq;
        logic        ovf;
        logic        unf;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] s, input logic o, input logic u, input int l);
        exp_t r;
        r.sq = s; r.ovf = o; r.unf = u; r.lat = l;
        return r;
    endfunction

    // Reference: native 48-bit multiply, then RNE on the top 24 significant bits.
    function automatic exp_t model(input logic [31:0] av);
        logic [7:0]  ex;
        logic [22:0] fr;
        logic [47:0] mm;
        logic [47:0] p;
        logic [22:0] f;
        logic        g;
        logic        s;
        int          e;
        int          fi;
        ex = av[30:23];
        fr = av[22:0];
        if (ex == 8'h00) return mk(32'h0, 1'b0, 1'b0, 0);
        if (ex == 8'hFF) return mk((fr == 23'h0) ? 32'h7F800000 : 32'h7FC00000, 1'b0, 1'b0, 0);
        mm = {24'h0, 1'b1, fr};
        p  = mm * mm;
        e  = 2 * int'(ex) - 127;
        if (p[47]) begin
            f = p[46:24]; g = p[23]; s = |p[22:0]; e++;
        end else begin
            f = p[45:23]; g = p[22]; s = |p[21:0];
        end
        fi = int'(f) + ((g && (s || f[0])) ? 1 : 0);
        if (fi == (1 << 23)) begin
            fi = 0; e++;
        end
        if (e >= 255) return mk(32'h7F800000, 1'b1, 1'b0, 25);
        if (e <= 0)   return mk(32'h0, 1'b0, 1'b1, 25);
        return mk({1'b0, 8'(e), 23'(fi)}, 1'b0, 1'b0, 25);
    endfunction

    // Called at a negedge; returns just after the accepting posedge.
    task automatic launch(input logic [31:0] av, input exp_t e);
        sb.push_back(e);
        a     = av;
        start = 1'b1;
        @(posedge clk);
    endtask

    // Called at a negedge n0 edges after acceptance; waits (bounded) for rdy.
    task automatic collect(input string tag, input int n0);
        int   n;
        bit   busy_ok;
        exp_t e;
        n       = n0;
        busy_ok = 1'b1;
        while (rdy !== 1'b1 && n < 60) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        check({tag, ".rdy"},      32'(rdy),       32'd1);
        check({tag, ".lat"},      32'(n),         32'(e.lat));
        check({tag, ".busy_run"}, 32'(busy_ok),   32'd1);
        check({tag, ".busy_end"}, 32'(busy),      32'd0);
        check({tag, ".sq"},       sq,             e.sq);
        check({tag, ".ovf"},      32'(overflow),  32'(e.ovf));
        check({tag, ".unf"},      32'(underflow), 32'(e.unf));
    endtask

    task automatic op(input string tag, input logic [31:0] av, input exp_t e);
        launch(av, e);
        @(negedge clk);
        start = 1'b0;
        collect(tag, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        rst   = 1'b1;
        start = 1'b0;
        a     = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.rdy",  32'(rdy),  32'd0);
        check("reset.sq",   sq,        32'h0);
        check("reset.ovf",  32'(overflow),  32'd0);
        check("reset.unf",  32'(underflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        op("three",    32'h40400000, mk(32'h41100000, 1'b0, 1'b0, 25));
        op("neg1p5",   32'hBFC00000, mk(32'h40100000, 1'b0, 1'b0, 25));
        op("one_ulp",  32'h3F800001, mk(32'h3F800002, 1'b0, 1'b0, 25));
        op("one",      32'h3F800000, mk(32'h3F800000, 1'b0, 1'b0, 25));
        op("big",      32'h60AD78EC, mk(32'h7F800000, 1'b1, 1'b0, 25));
        op("tiny",     32'h0DA24260, mk(32'h00000000, 1'b0, 1'b1, 25));
        op("zero",     32'h00000000, mk(32'h00000000, 1'b0, 1'b0, 0));
        op("denorm",   32'h00012345, mk(32'h00000000, 1'b0, 1'b0, 0));
        op("inf",      32'h7F800000, mk(32'h7F800000, 1'b0, 1'b0, 0));
        op("nan",      32'h7F812345, mk(32'h7FC00000, 1'b0, 1'b0, 0));
        op("minnorm",  32'h20000000, mk(32'h00800000, 1'b0, 1'b0, 25));
        op("below",    32'h1F800000, mk(32'h00000000, 1'b0, 1'b1, 25));
        op("maxexp",   32'h5F000000, mk(32'h7E800000, 1'b0, 1'b0, 25));
        op("above",    32'h5F800000, mk(32'h7F800000, 1'b1, 1'b0, 25));
        op("allones",  32'h3FFFFFFF, mk(32'h407FFFFE, 1'b0, 1'b0, 25));

        // start pulsed mid-MULT with a different operand must be ignored
        launch(32'h40400000, mk(32'h41100000, 1'b0, 1'b0, 25));
        @(negedge clk);
        start = 1'b0;
        repeat (5) begin @(posedge clk); @(negedge clk); end
        a     = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        collect("ignore", 6);

        // async reset at MULT cycle 10 clears everything, including the held 9.0
        launch(32'h40000000, mk(32'h40800000, 1'b0, 1'b0, 25));
        @(negedge clk);
        start = 1'b0;
        repeat (10) begin @(posedge clk); @(negedge clk); end
        void'(sb.pop_back());
        rst = 1'b1;
        #1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.rdy",  32'(rdy),  32'd0);
        check("abort.sq",   sq,        32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        op("after_rst", 32'h40000000, mk(32'h40800000, 1'b0, 1'b0, 25));

        // start held high through DONE restarts back-to-back
        launch(32'h40400000, mk(32'h41100000, 1'b0, 1'b0, 25));
        @(negedge clk);
        collect("b2b_first", 0);
        launch(32'hBFC00000, mk(32'h40100000, 1'b0, 1'b0, 25));
        @(negedge clk);
        start = 1'b0;
        check("b2b.rdy_drop", 32'(rdy),  32'd0);
        check("b2b.busy",     32'(busy), 32'd1);
        collect("b2b_second", 0);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            ra[30:23] = 8'($urandom_range(190, 64));
            op($sformatf("rnd%0d", i), ra, model(ra));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
